aes_req_scheduler: RTL and testbench

Round-robin scheduler that shares one aes_cipher_top instance among NREQ requesters. It grants one request at a time and latches that request's key and plaintext into registers driving the core. It pulses core_ld, waits for core_done with a stale-done guard and a timeout, then holds the result in a response register with valid/ready backpressure. It sits between the requester fabric and the AES core and owns every core input.

---
 rtl/aes_req_scheduler.sv | 120 ++++++++++++
 tb/tb_aes_req_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler that time-shares one AES core among NREQ requesters.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high; valid holds its payload until then.
module aes_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [128*NREQ-1:0]  req_key,
  input  logic [128*NREQ-1:0]  req_text,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [127:0]         rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 core_ld,
  output logic [127:0]         core_key,
  output logic [127:0]         core_text_in,
  input  logic [127:0]         core_text_out,
  input  logic                 core_done,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  cand;
  logic            gvalid;
  logic [CW-1:0]   cnt;
  logic            done_ok;
  logic            tmo;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!gvalid && req_valid[cand]) begin
        gvalid = 1'b1;
        gidx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gvalid) req_ready[gidx] = 1'b1;
  end

  // A done level may linger from the previous operation, so ignore it for the first two WAIT cycles.
  assign done_ok   = core_done && (cnt >= CW'(2));
  assign tmo       = (cnt == CW'(TIMEOUT));
  assign core_ld   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gvalid) state_nx = LOAD;
      LOAD:    state_nx = WAIT;
      WAIT:    if (done_ok || tmo) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= IDW'(NREQ - 1);
      cnt          <= '0;
      core_key     <= '0;
      core_text_in <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gvalid) begin
            core_key     <= req_key[128*gidx +: 128];
            core_text_in <= req_text[128*gidx +: 128];
            rsp_id       <= gidx;
            ptr          <= gidx;
          end
        end
        LOAD: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // Done takes priority over a timeout in the same cycle.
          if (done_ok) begin
            rsp_data  <= core_text_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (tmo) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler: requester drivers, a behavioural AES-core stand-in,
// a round-robin reference model and a response scoreboard.
module tb_aes_req_scheduler;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 31;
  localparam int W       = IDW + 129;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [128*NREQ-1:0] req_key, req_text;
  logic                rsp_valid, rsp_ready;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic                core_ld;
  logic [127:0]        core_key, core_text_in, core_text_out;
  logic                core_done;
  logic                busy;
  logic [1:0]          dbg_state;

  aes_req_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_text_out(core_text_out), .core_done(core_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]   exp_q[$];
  logic [255:0]   job_q[NREQ][$];
  bit   [NREQ-1:0] hs_flag = '0;
  int   rsp_mode  = 0;
  int   core_mode = 0;
  int   force_lat = 0;
  int   cur_lat   = 0;
  int   m_ptr     = NREQ - 1;
  bit   outstanding = 0;
  bit   ld_expect   = 0;
  logic [255:0] ld_job;
  int   cyc = 0;
  int   ld_cyc = 0;
  bit   prev_valid = 0;
  bit   prev_hs = 0;
  logic [W-1:0] prev_rsp;
  int   grant_log[$];
  int   resp_ids[$];
  logic [127:0] last_data[NREQ];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
    if (k == K1 && t == P1) return C1;
    if (k == K2 && t == P2) return C2;
    return k ^ {t[63:0], t[127:64]} ^ 128'h3c3c_a5a5_0f0f_9696_3c3c_a5a5_0f0f_9696;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit pending();
    bit p;
    p = outstanding || (exp_q.size() != 0);
    for (int i = 0; i < NREQ; i++) if (job_q[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic enqueue(input int i, input logic [127:0] k, input logic [127:0] t);
    job_q[i].push_back({k, t});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("wait_idle");
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_core_ld", core_ld, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_text_in", core_text_in, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    exp_q.delete();
    outstanding = 0;
    ld_expect   = 0;
    prev_valid  = 0;
    m_ptr       = NREQ - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- requester / responder driver ----------------
  initial begin
    logic [255:0] j;
    req_valid = '0;
    req_key   = '0;
    req_text  = '0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_flag[i]) begin
          void'(job_q[i].pop_front());
          hs_flag[i] = 1'b0;
        end
        if (job_q[i].size() != 0) begin
          j = job_q[i][0];
          req_valid[i]            = 1'b1;
          req_key[128*i +: 128]   = j[255:128];
          req_text[128*i +: 128]  = j[127:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if (rsp_mode == 0)      rsp_ready = 1'b1;
      else if (rsp_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
      else                    rsp_ready = 1'b0;
    end
  end

  // ---------------- AES core stand-in ----------------
  // mode 0: one-cycle done pulse; mode 1: never done; mode 2: done stays high until two cycles into the next op.
  initial begin
    logic [127:0] pend_res;
    int  cd;
    bit  running;
    core_done     = 1'b0;
    core_text_out = '0;
    cd            = 0;
    running       = 0;
    pend_res      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_done = 1'b0;
        running   = 0;
      end else if (core_ld) begin
        pend_res = fake_aes(core_key, core_text_in);
        cd       = 0;
        running  = (core_mode != 1);
        if (force_lat > 0)       cur_lat = force_lat;
        else if (core_mode == 2) cur_lat = int'($urandom_range(4, 12));
        else                     cur_lat = int'($urandom_range(3, 12));
        if (core_mode != 2) core_done = 1'b0;
      end else if (running) begin
        cd++;
        if (core_mode == 2 && cd == 3) core_done = 1'b0;
        if (cd == cur_lat) begin
          core_done     = 1'b1;
          core_text_out = pend_res;
          if (core_mode == 2) running = 0;
        end else if (cd == cur_lat + 1) begin
          core_done = 1'b0;
          running   = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int g;
    logic [NREQ-1:0] exp_rr;
    logic [W-1:0] e;
    logic [255:0] job;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b0) begin
        prev_valid = 0;
        continue;
      end
      check("busy", busy, outstanding);
      check("core_ld", core_ld, ld_expect);
      if (ld_expect) begin
        check("core_key", core_key, ld_job[255:128]);
        check("core_text_in", core_text_in, ld_job[127:0]);
        ld_cyc = cyc;
      end
      ld_expect = 0;

      if (!outstanding) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        check("req_ready_grant", req_ready, exp_rr);
        if (g >= 0) begin
          job         = job_q[g][0];
          ld_job      = job;
          m_ptr       = g;
          outstanding = 1;
          ld_expect   = 1;
          hs_flag[g]  = 1'b1;
          grant_log.push_back(g);
          if (core_mode == 1) exp_q.push_back({1'b1, IDW'(g), 128'h0});
          else                exp_q.push_back({1'b0, IDW'(g), fake_aes(job[255:128], job[127:0])});
        end
      end else begin
        check("req_ready_busy", req_ready, 0);
      end

      if (rsp_valid) begin
        if (prev_valid && !prev_hs) check("rsp_stable", {rsp_err, rsp_id, rsp_data}, prev_rsp);
        if (!prev_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          check("rsp_latency", cyc - ld_cyc, e[W-1] ? TIMEOUT + 2 : cur_lat + 1);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e[127+IDW:128]);
            check("rsp_data", rsp_data, e[127:0]);
            check("rsp_err", rsp_err, e[W-1]);
            resp_ids.push_back(int'(rsp_id));
            last_data[rsp_id] = rsp_data;
          end
          outstanding = 0;
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_rsp   = {rsp_err, rsp_id, rsp_data};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fail_now("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_data", rsp_data, 0);
    check("init_rsp_id", rsp_id, 0);
    check("init_rsp_err", rsp_err, 0);
    check("init_core_ld", core_ld, 0);
    check("init_core_key", core_key, 0);
    check("init_core_text_in", core_text_in, 0);
    check("init_busy", busy, 0);
    check("init_req_ready", req_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // single known-answer request, shortest accepted latency
    force_lat = 3;
    enqueue(1, K1, P1);
    wait_idle(200);
    check("t1_data", last_data[1], C1);
    force_lat = 0;

    // all four from reset
    do_reset();
    resp_ids.delete();
    enqueue(0, rand128(), rand128());
    enqueue(1, K1, P1);
    enqueue(2, K2, P2);
    enqueue(3, rand128(), rand128());
    wait_idle(400);
    check("t2_count", resp_ids.size(), 4);
    for (int k = 0; k < resp_ids.size(); k++) check("t2_order", resp_ids[k], k);
    check("t2_id2_data", last_data[2], C2);

    // response backpressure with another requester waiting
    rsp_mode = 2;
    enqueue(0, rand128(), rand128());
    n = 0;
    while (!outstanding && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t3_grant");
    enqueue(3, rand128(), rand128());
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("t3_rsp_valid");
    repeat (20) @(negedge clk);
    rsp_mode = 0;
    wait_idle(200);

    // timeout, then done colliding with the timeout cycle, then normal service
    core_mode = 1;
    enqueue(2, rand128(), rand128());
    wait_idle(300);
    check("t4_err_data", last_data[2], 0);
    core_mode = 0;
    force_lat = TIMEOUT + 1;
    enqueue(1, rand128(), rand128());
    wait_idle(300);
    force_lat = 0;
    enqueue(0, rand128(), rand128());
    wait_idle(200);

    // stale done level carried into the next op
    core_mode = 2;
    enqueue(0, rand128(), rand128());
    wait_idle(200);
    enqueue(1, rand128(), rand128());
    wait_idle(200);
    enqueue(2, K2, P2);
    wait_idle(200);
    check("t5_stale_data", last_data[2], C2);

    // reset in the middle of WAIT drops the op
    core_mode = 1;
    enqueue(2, rand128(), rand128());
    n = 0;
    while (!outstanding && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t5_grant");
    repeat (6) @(negedge clk);
    do_reset();
    core_mode = 0;
    repeat (10) @(negedge clk);
    check("t5_no_rsp", rsp_valid, 0);
    check("t5_idle", busy, 0);
    enqueue(3, rand128(), rand128());
    wait_idle(200);

    // two continuous requesters alternate
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      enqueue(0, rand128(), rand128());
      enqueue(2, rand128(), rand128());
    end
    wait_idle(600);
    check("t6_count", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size(); k++) check("t6_order", grant_log[k], (k % 2) * 2);

    // randomized traffic with random backpressure and latency
    rsp_mode = 1;
    for (int k = 0; k < 60; k++) begin
      enqueue(int'($urandom_range(0, NREQ - 1)), rand128(), rand128());
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_idle(8000);
    rsp_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
